// File: rtl/control_alarma_temp.sv
// Periodic ADC temperature sampler with range classification and a persistent alarm.
// Define CONTROL_ALARMA_HISTERESIS_EN to require a release margin before alarma clears.
module control_alarma_temp #(
  parameter int unsigned PERIODO_MUESTREO = 1000,
  parameter int unsigned TIMEOUT_ADC      = 64,
  parameter int          TEMP_MIN         = -100,
  parameter int          TEMP_MAX         = 600,
  parameter int unsigned PERSISTENCIA     = 3,
  parameter int unsigned HISTERESIS       = 20
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               habilitar,
  input  logic               adc_listo,
  input  logic signed [10:0] adc_dato,
  output logic               adc_iniciar,
  output logic signed [10:0] temp_actual,
  output logic               temp_valida,
  output logic               fuera_rango,
  output logic [2:0]         contador_persist,
  output logic               alarma,
  output logic               error_timeout
);

  localparam int unsigned PerW = (PERIODO_MUESTREO > 1) ? $clog2(PERIODO_MUESTREO) : 1;
  localparam int unsigned ToW  = (TIMEOUT_ADC > 1) ? $clog2(TIMEOUT_ADC) : 1;
  localparam logic [PerW-1:0] PerLast = PerW'(PERIODO_MUESTREO - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_ADC - 1);
  localparam logic signed [10:0] TMin  = 11'(TEMP_MIN);
  localparam logic signed [10:0] TMax  = 11'(TEMP_MAX);
  localparam logic signed [10:0] SatHi = 11'sd850;
  localparam logic signed [10:0] SatLo = -11'sd400;
  localparam logic [2:0] Persist = 3'(PERSISTENCIA);
`ifdef CONTROL_ALARMA_HISTERESIS_EN
  localparam logic signed [10:0] TRelMin = 11'(TEMP_MIN + int'(HISTERESIS));
  localparam logic signed [10:0] TRelMax = 11'(TEMP_MAX - int'(HISTERESIS));
`endif

  typedef enum logic [1:0] {StReposo, StEspera, StConvirtiendo, StEvaluando} estado_t;

  estado_t state_q, state_d;
  logic [PerW-1:0] per_q, per_d;
  logic [ToW-1:0]  to_q, to_d;
  logic signed [10:0] temp_q, temp_d, dato_sat;
  logic fuera_q, fuera_d, alarma_q, alarma_d, err_q, err_d;
  logic ini_q, ini_d, val_q, val_d, fuera_now;
  logic [2:0] cnt_q, cnt_d, cnt_nxt;

  always_comb begin
    if (adc_dato > SatHi)      dato_sat = SatHi;
    else if (adc_dato < SatLo) dato_sat = SatLo;
    else                       dato_sat = adc_dato;
  end

  assign fuera_now = (temp_q < TMin) || (temp_q > TMax);
  assign cnt_nxt   = !fuera_now ? 3'd0 : (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    to_d     = to_q;
    temp_d   = temp_q;
    fuera_d  = fuera_q;
    cnt_d    = cnt_q;
    alarma_d = alarma_q;
    err_d    = err_q;
    ini_d    = 1'b0;
    val_d    = 1'b0;
    // The period counter keeps running through conversion so starts stay evenly spaced.
    if (state_q != StReposo) per_d = (per_q == PerLast) ? '0 : per_q + 1'b1;
    unique case (state_q)
      StReposo: begin
        if (habilitar) begin
          state_d = StEspera;
          per_d   = '0;
          err_d   = 1'b0;
        end
      end
      StEspera: begin
        if (!habilitar) begin
          state_d = StReposo;
        end else if (per_q == PerLast) begin
          ini_d   = 1'b1;
          to_d    = '0;
          state_d = StConvirtiendo;
        end
      end
      StConvirtiendo: begin
        if (adc_listo) begin
          temp_d  = dato_sat;
          state_d = StEvaluando;
        end else if (to_q == ToLast) begin
          err_d   = 1'b1;
          state_d = habilitar ? StEspera : StReposo;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StEvaluando: begin
        fuera_d = fuera_now;
        cnt_d   = cnt_nxt;
        val_d   = 1'b1;
        if (cnt_nxt >= Persist) begin
          alarma_d = 1'b1;
        end else if (!fuera_now) begin
`ifdef CONTROL_ALARMA_HISTERESIS_EN
          if (temp_q >= TRelMin && temp_q <= TRelMax) alarma_d = 1'b0;
`else
          alarma_d = 1'b0;
`endif
        end
        state_d = habilitar ? StEspera : StReposo;
      end
      default: state_d = StReposo;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= StReposo;
      per_q    <= '0;
      to_q     <= '0;
      temp_q   <= '0;
      fuera_q  <= 1'b0;
      cnt_q    <= 3'd0;
      alarma_q <= 1'b0;
      err_q    <= 1'b0;
      ini_q    <= 1'b0;
      val_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      to_q     <= to_d;
      temp_q   <= temp_d;
      fuera_q  <= fuera_d;
      cnt_q    <= cnt_d;
      alarma_q <= alarma_d;
      err_q    <= err_d;
      ini_q    <= ini_d;
      val_q    <= val_d;
    end
  end

  assign adc_iniciar      = ini_q;
  assign temp_actual      = temp_q;
  assign temp_valida      = val_q;
  assign fuera_rango      = fuera_q;
  assign contador_persist = cnt_q;
  assign alarma           = alarma_q;
  assign error_timeout    = err_q;

endmodule

// File: tb/tb_control_alarma_temp.sv
// Directed bench for control_alarma_temp: sampling period, classification table,
// saturation, timeout and mid-conversion reset.
module tb_control_alarma_temp;

  logic               clk = 1'b0;
  logic               arst_n, habilitar, adc_listo;
  logic signed [10:0] adc_dato;
  logic               adc_iniciar, temp_valida, fuera_rango, alarma, error_timeout;
  logic signed [10:0] temp_actual;
  logic [2:0]         contador_persist;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

`ifdef CONTROL_ALARMA_HISTERESIS_EN
  localparam bit HystOn = 1'b1;
`else
  localparam bit HystOn = 1'b0;
`endif

  control_alarma_temp #(.PERIODO_MUESTREO(10)) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .habilitar        (habilitar),
    .adc_listo        (adc_listo),
    .adc_dato         (adc_dato),
    .adc_iniciar      (adc_iniciar),
    .temp_actual      (temp_actual),
    .temp_valida      (temp_valida),
    .fuera_rango      (fuera_rango),
    .contador_persist (contador_persist),
    .alarma           (alarma),
    .error_timeout    (error_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int dato;
    int e_temp;
    int e_fuera;
    int e_cnt;
    int e_alarma;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_iniciar(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (adc_iniciar) ok = 1'b1;
    end
    check({name, "_iniciar_seen"}, int'(ok), 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_iniciar"}, int'(adc_iniciar), 0);
    check({name, "_temp"}, int'(temp_actual), 0);
    check({name, "_valida"}, int'(temp_valida), 0);
    check({name, "_fuera"}, int'(fuera_rango), 0);
    check({name, "_cnt"}, int'(contador_persist), 0);
    check({name, "_alarma"}, int'(alarma), 0);
    check({name, "_err"}, int'(error_timeout), 0);
  endtask

  // Wait for a start pulse, answer it in the same cycle, then check capture and evaluation.
  task automatic do_sample(input int idx, input vec_t v);
    bit ok;
    wait_iniciar($sformatf("row%0d", idx), ok);
    if (ok) begin
      adc_listo = 1'b1;
      adc_dato  = 11'(v.dato);
      @(negedge clk);
      adc_listo = 1'b0;
      check($sformatf("row%0d_temp", idx), int'(temp_actual), v.e_temp);
      check($sformatf("row%0d_valida_early", idx), int'(temp_valida), 0);
      @(negedge clk);
      check($sformatf("row%0d_valida", idx), int'(temp_valida), 1);
      check($sformatf("row%0d_fuera", idx), int'(fuera_rango), v.e_fuera);
      check($sformatf("row%0d_cnt", idx), int'(contador_persist), v.e_cnt);
      check($sformatf("row%0d_alarma", idx), int'(alarma), v.e_alarma);
      @(negedge clk);
      check($sformatf("row%0d_valida_pulse", idx), int'(temp_valida), 0);
    end
  endtask

  // Let one conversion go unanswered and check the timeout lands exactly 64 cycles later.
  task automatic do_timeout(input string name, input int exp_temp);
    bit ok;
    int k;
    wait_iniciar(name, ok);
    k = 0;
    if (ok) begin
      for (int i = 1; i <= 200 && k == 0; i++) begin
        @(negedge clk);
        if (error_timeout) k = i;
      end
      check({name, "_latency"}, k, 64);
      check({name, "_temp_held"}, int'(temp_actual), exp_temp);
      check({name, "_valida"}, int'(temp_valida), 0);
    end
  endtask

  initial begin
    bit ok;
    int t_prev, t_now;
    bit seen;

    vecs[0]  = '{700, 700, 1, 1, 0};
    vecs[1]  = '{700, 700, 1, 2, 0};
    vecs[2]  = '{700, 700, 1, 3, 1};
    vecs[3]  = '{250, 250, 0, 0, 0};
    vecs[4]  = '{-100, -100, 0, 0, 0};
    vecs[5]  = '{600, 600, 0, 0, 0};
    vecs[6]  = '{601, 601, 1, 1, 0};
    vecs[7]  = '{1023, 850, 1, 2, 0};
    vecs[8]  = '{-1024, -400, 1, 3, 1};
    vecs[9]  = '{590, 590, 0, 0, int'(HystOn)};
    vecs[10] = '{500, 500, 0, 0, 0};

    arst_n    = 1'b0;
    habilitar = 1'b0;
    adc_listo = 1'b0;
    adc_dato  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    arst_n = 1'b1;

    // Idle with habilitar low: no conversions start.
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (adc_iniciar) seen = 1'b1;
    end
    check("idle_no_iniciar", int'(seen), 0);

    // Periodic sampling: starts 10 cycles apart, one cycle wide.
    habilitar = 1'b1;
    t_prev = -1;
    for (int p = 0; p < 4; p++) begin
      wait_iniciar($sformatf("period%0d", p), ok);
      if (ok) begin
        t_now = cyc;
        if (t_prev >= 0) check($sformatf("period%0d_spacing", p), t_now - t_prev, 10);
        t_prev    = t_now;
        adc_listo = 1'b1;
        adc_dato  = '0;
        @(negedge clk);
        adc_listo = 1'b0;
        check($sformatf("period%0d_width", p), int'(adc_iniciar), 0);
      end
    end

    for (int i = 0; i < 11; i++) do_sample(i, vecs[i]);

    // Timeout sets the sticky flag and sampling resumes.
    do_timeout("to1", 500);
    wait_iniciar("to1_resume", ok);
    if (ok) begin
      adc_listo = 1'b1;
      adc_dato  = 11'sd300;
      @(negedge clk);
      adc_listo = 1'b0;
      @(negedge clk);
      check("to1_sticky", int'(error_timeout), 1);
      check("to1_resume_temp", int'(temp_actual), 300);
    end

    // Sticky through REPOSO, cleared on REPOSO->ESPERA.
    habilitar = 1'b0;
    repeat (5) @(negedge clk);
    check("reposo_err_held", int'(error_timeout), 1);
    check("reposo_temp_held", int'(temp_actual), 300);
    habilitar = 1'b1;
    @(negedge clk);
    check("espera_err_cleared", int'(error_timeout), 0);

    // Second timeout, then reset in the middle of the following conversion.
    do_timeout("to2", 300);
    wait_iniciar("rst_mid", ok);
    if (ok) begin
      habilitar = 1'b0;
      arst_n    = 1'b0;
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      arst_n = 1'b1;
      // A late ready pulse belongs to the aborted conversion and must be ignored.
      adc_listo = 1'b1;
      adc_dato  = 11'sd700;
      @(negedge clk);
      adc_listo = 1'b0;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (temp_valida || adc_iniciar) seen = 1'b1;
      end
      check("late_listo_ignored", int'(seen), 0);
      check_all_zero("after_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_alarma_temp.md
CONTROL_ALARMA_TEMP -- requirements
Module: control_alarma_temp

Interface
REQ-001 SHALL provide parameter PERIODO_MUESTREO, default 1000, cycles from one conversion start to the next.
REQ-002 SHALL provide parameter TIMEOUT_ADC, default 64, maximum cycles to wait for adc_listo.
REQ-003 SHALL provide parameter TEMP_MIN, default -100, signed lower normal limit in 0.1 degC.
REQ-004 SHALL provide parameter TEMP_MAX, default 600, signed upper normal limit in 0.1 degC.
REQ-005 SHALL provide parameter PERSISTENCIA, default 3, range 1..7, consecutive out-of-range samples needed to raise alarma.
REQ-006 SHALL provide parameter HISTERESIS, default 20, alarm-release margin in 0.1 degC.
REQ-007 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  system clock (rising edge).
REQ-008 SHALL provide arst_n  in  1  asynchronous active-low reset.
REQ-009 SHALL provide habilitar  in  1  level; 1 runs periodic sampling.
REQ-010 SHALL provide adc_listo  in  1  one-cycle pulse; adc_dato valid this cycle.
REQ-011 SHALL provide adc_dato  in  11 signed  raw conversion result.
REQ-012 SHALL provide adc_iniciar  out  1  one-cycle conversion start pulse.
REQ-013 SHALL provide temp_actual  out  11 signed  last captured, saturated temperature.
REQ-014 SHALL provide temp_valida  out  1  one-cycle pulse when classification outputs update.
REQ-015 SHALL provide fuera_rango  out  1  last sample outside [TEMP_MIN, TEMP_MAX].
REQ-016 SHALL provide contador_persist  out  3  consecutive out-of-range sample count.
REQ-017 SHALL provide alarma  out  1  persistent over/under-temperature alarm.
REQ-018 SHALL provide error_timeout  out  1  sticky ADC timeout flag.

Function
REQ-019 SHALL implement FSM states REPOSO, ESPERA, CONVIRTIENDO, EVALUANDO.
REQ-020 SHALL, in REPOSO with habilitar=1, enter ESPERA next cycle with period counter cleared.
REQ-021 SHALL, in ESPERA, count to PERIODO_MUESTREO-1, then pulse adc_iniciar for one cycle and enter CONVIRTIENDO.
REQ-022 SHALL, in CONVIRTIENDO, on adc_listo=1 capture adc_dato into temp_actual on that edge and enter EVALUANDO.
REQ-023 SHALL saturate captured adc_dato to [-400, 850] before storing it in temp_actual.
REQ-024 SHALL, if TIMEOUT_ADC cycles elapse in CONVIRTIENDO without adc_listo, set error_timeout, leave all other outputs unchanged, and return to ESPERA.
REQ-025 SHALL ignore adc_listo in every state except CONVIRTIENDO.
REQ-026 SHALL, in EVALUANDO (exactly one cycle), update fuera_rango, contador_persist and alarma, and pulse temp_valida, so that these outputs change two edges after the adc_listo cycle.
REQ-027 SHALL treat TEMP_MIN and TEMP_MAX themselves as in range.
REQ-028 SHALL increment contador_persist on out-of-range samples, saturate it at 7, and clear it to 0 on any in-range sample.
REQ-029 SHALL set alarma in the EVALUANDO cycle in which the updated count is greater than or equal to PERSISTENCIA.
REQ-030 SHALL clear alarma according to REQ-040/REQ-041.
REQ-031 SHALL, with habilitar=0, go from ESPERA to REPOSO next cycle; from CONVIRTIENDO, SHALL finish the conversion or time out, evaluate, then go to REPOSO.
REQ-032 SHALL hold all outputs in REPOSO; error_timeout SHALL clear on the REPOSO->ESPERA transition.

Reset
REQ-033 SHALL, on arst_n=0, immediately force state REPOSO and all counters to 0.
REQ-034 SHALL, on arst_n=0, immediately force temp_actual=0, fuera_rango=0, contador_persist=0, alarma=0, adc_iniciar=0, temp_valida=0, error_timeout=0.
REQ-035 SHALL, when reset is asserted mid-conversion, abort the conversion and discard any later adc_listo until the next adc_iniciar.

Configuration
REQ-036 SHALL support the macro CONTROL_ALARMA_HISTERESIS_EN.
REQ-040 SHALL, with CONTROL_ALARMA_HISTERESIS_EN defined, clear alarma only on a sample within [TEMP_MIN+HISTERESIS, TEMP_MAX-HISTERESIS]; in-range samples inside the margin SHALL clear the counter but hold alarma.
REQ-041 SHALL, without CONTROL_ALARMA_HISTERESIS_EN, clear alarma on the first in-range sample.

Verification
REQ-042 SHALL check periodic sampling: habilitar=1, PERIODO_MUESTREO=10 -> adc_iniciar pulses exactly 10 cycles apart, one cycle wide.
REQ-043 SHALL check persistence: samples 700,700,700 -> contador_persist 1,2,3; alarma rises with the third temp_valida; sample 250 -> counter 0 and alarma 0 (macro off).
REQ-044 SHALL check hysteresis: macro on, alarm active, sample 590 -> alarma stays 1; sample 500 -> alarma 0.
REQ-045 SHALL check boundaries: samples -100 and 600 -> fuera_rango 0; sample 601 -> 1; adc_dato 1023 -> temp_actual 850; adc_dato -1024 -> -400.
REQ-046 SHALL check timeout: no adc_listo for 64 cycles -> error_timeout=1, FSM returns to ESPERA; arst_n pulse mid-conversion -> all outputs 0, state REPOSO.
